// File: rtl/axil_ram_ext_if.sv
// AXI4-Lite bus bundle for axil_ram_ext: AW, W, B, AR and R channels with master/slave views.
interface axil_ram_ext_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axil_ram_ext.sv
// AXI4-Lite slave RAM: decoupled AW/W holding registers, SLVERR on out-of-range access, programmable
// read latency. Define AXIL_RAM_PROT_EN to block unprivileged access to words at or above PROT_BASE.
module axil_ram_ext #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int PROT_BASE    = MEM_WORDS / 2
) (
    input logic          clk,
    input logic          rst,
    axil_ram_ext_if.slave s_axil
);
    localparam int          ADDR_LSB    = $clog2(STRB_WIDTH);
    localparam int          MEM_AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);
    localparam logic [31:0] PROT_BASE_U = 32'(PROT_BASE);
    localparam logic [3:0]  RD_CNT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rd_state_t;

    logic                  aw_full_reg;
    logic                  w_full_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [2:0]            aw_prot_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;

    rd_state_t             state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [1:0]            rresp_reg;
    logic                  arready_int;
    logic                  rvalid_int;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  w_ok, r_ok;
    logic [31:0]           w_word, r_word;
    logic [MEM_AW-1:0]     w_idx, r_idx;
    logic                  unused_prot;

    assign aw_hs  = s_axil.awvalid && s_axil.awready;
    assign w_hs   = s_axil.wvalid && s_axil.wready;
    assign ar_hs  = s_axil.arvalid && s_axil.arready;
    assign commit = aw_full_reg && w_full_reg && (!bvalid_reg || s_axil.bready) && !rst;

    assign w_word = 32'(aw_addr_reg >> ADDR_LSB);
    assign r_word = 32'(s_axil.araddr >> ADDR_LSB);
    assign w_idx  = aw_addr_reg[ADDR_LSB +: MEM_AW];
    assign r_idx  = s_axil.araddr[ADDR_LSB +: MEM_AW];

`ifdef AXIL_RAM_PROT_EN
    assign w_ok = (w_word < MEM_WORDS_U) && (aw_prot_reg[0] || (w_word < PROT_BASE_U));
    assign r_ok = (r_word < MEM_WORDS_U) && (s_axil.arprot[0] || (r_word < PROT_BASE_U));
`else
    assign w_ok = (w_word < MEM_WORDS_U);
    assign r_ok = (r_word < MEM_WORDS_U);
`endif

    // Protection bits and base are only partly (or not at all) consumed depending on the build.
    assign unused_prot = ^{aw_prot_reg, s_axil.arprot, PROT_BASE_U};

    // Write channel: AW and W each park in a one-deep register; the pair commits together.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
        end else if (commit) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= w_ok ? 2'b00 : 2'b10;
        end else begin
            if (aw_hs) aw_full_reg <= 1'b1;
            if (w_hs) w_full_reg <= 1'b1;
            if (bvalid_reg && s_axil.bready) bvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_addr_reg <= s_axil.awaddr;
            aw_prot_reg <= s_axil.awprot;
        end
        if (w_hs) begin
            w_data_reg <= s_axil.wdata;
            w_strb_reg <= s_axil.wstrb;
        end
    end

    // One RAM per byte lane; the read register samples before the same-edge write lands.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi = gi + 1) begin : g_lane
            logic [7:0] mem [MEM_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && w_ok && w_strb_reg[gi]) mem[w_idx] <= w_data_reg[gi*8 +: 8];
                if (ar_hs) rd_byte_reg <= r_ok ? mem[r_idx] : 8'h00;
            end

            assign rd_data[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            rresp_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (ar_hs) rresp_reg <= r_ok ? 2'b00 : 2'b10;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        arready_int = 1'b0;
        rvalid_int  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                arready_int = 1'b1;
                if (ar_hs) begin
                    cnt_next   = RD_CNT_INIT;
                    state_next = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = S_RESP;
            end
            S_RESP: begin
                rvalid_int = 1'b1;
                if (s_axil.rready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign s_axil.awready = !aw_full_reg && !rst;
    assign s_axil.wready  = !w_full_reg && !rst;
    assign s_axil.bvalid  = bvalid_reg && !rst;
    assign s_axil.bresp   = rst ? 2'b00 : bresp_reg;
    assign s_axil.arready = arready_int && !rst;
    assign s_axil.rvalid  = rvalid_int && !rst;
    assign s_axil.rresp   = rst ? 2'b00 : rresp_reg;
    assign s_axil.rdata   = rst ? '0 : rd_data;
endmodule

// File: tb/tb_axil_ram_ext.sv
// Directed bench for axil_ram_ext: one instance at read latency 1, one at latency 4, sharing write traffic.
module tb_axil_ram_ext;
    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          sel4 = 0;

    axil_ram_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
    axil_ram_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if4 ();

    assign if1.awaddr = awaddr;  assign if4.awaddr = awaddr;
    assign if1.awprot = awprot;  assign if4.awprot = awprot;
    assign if1.awvalid = awvalid; assign if4.awvalid = awvalid;
    assign if1.wdata = wdata;    assign if4.wdata = wdata;
    assign if1.wstrb = wstrb;    assign if4.wstrb = wstrb;
    assign if1.wvalid = wvalid;  assign if4.wvalid = wvalid;
    assign if1.bready = bready;  assign if4.bready = bready;
    assign if1.araddr = araddr;  assign if4.araddr = araddr;
    assign if1.arprot = arprot;  assign if4.arprot = arprot;
    assign if1.arvalid = arvalid && !sel4;
    assign if4.arvalid = arvalid && sel4;
    assign if1.rready = rready && !sel4;
    assign if4.rready = rready && sel4;

    wire          awready_o = if1.awready;
    wire          wready_o  = if1.wready;
    wire          bvalid_o  = if1.bvalid;
    wire [1:0]    bresp_o   = if1.bresp;
    wire          arready_s = sel4 ? if4.arready : if1.arready;
    wire          rvalid_s  = sel4 ? if4.rvalid : if1.rvalid;
    wire [1:0]    rresp_s   = sel4 ? if4.rresp : if1.rresp;
    wire [DW-1:0] rdata_s   = sel4 ? if4.rdata : if1.rdata;

    axil_ram_ext #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .s_axil(if1));
    axil_ram_ext #(.READ_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .s_axil(if4));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [2:0] p, output logic [1:0] resp, output int lat);
        logic aw_done, w_done, aw_now, w_now;
        int guard;
        awaddr = a; awprot = p; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
        aw_done = 0; w_done = 0; guard = 0;
        while (!(aw_done && w_done) && guard < 50) begin
            aw_now = awvalid && awready_o;
            w_now  = wvalid && wready_o;
            tick;
            guard++;
            if (aw_now) begin aw_done = 1; awvalid = 0; end
            if (w_now) begin w_done = 1; wvalid = 0; end
        end
        awvalid = 0; wvalid = 0;
        chk("wr_accept", 32'(aw_done && w_done), 32'd1);
        lat = 0;
        while (!bvalid_o && lat < 50) begin tick; lat++; end
        chk("wr_bvalid", 32'(bvalid_o), 32'd1);
        resp = bresp_o;
        bready = 1; tick; bready = 0;
        $display("write addr=%h data=%h strb=%h prot=%0d bresp=%0d lat=%0d", a, d, s, p, resp, lat);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p,
                           output logic [DW-1:0] data, output logic [1:0] resp, output int lat);
        int guard;
        araddr = a; arprot = p; arvalid = 1; guard = 0;
        while (!arready_s && guard < 50) begin tick; guard++; end
        chk("rd_accept", 32'(arready_s), 32'd1);
        tick;
        arvalid = 0;
        lat = 0;
        while (!rvalid_s && lat < 50) begin tick; lat++; end
        chk("rd_rvalid", 32'(rvalid_s), 32'd1);
        data = rdata_s; resp = rresp_s;
        rready = 1; tick; rready = 0;
        $display("read  addr=%h prot=%0d inst=%0d rdata=%h rresp=%0d lat=%0d", a, p, sel4 ? 4 : 1, data, resp, lat);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic [1:0]    exp_bresp;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_rresp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [1:0]    r, rr;
        logic [DW-1:0] d, held;
        logic          bv;
        int            lat, rlat;

        vecs[0] = '{16'h0000, 32'hA5A5_0001, 4'hF, 2'b00, 32'hA5A5_0001, 2'b00};
        vecs[1] = '{16'h0FFC, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0BAD_F00D, 2'b00};
        vecs[2] = '{16'h0FFF, 32'h1111_2222, 4'h3, 2'b00, 32'h0BAD_2222, 2'b00};
        vecs[3] = '{16'h1000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[4] = '{16'h0002, 32'h9988_7766, 4'h8, 2'b00, 32'h99A5_0001, 2'b00};
        vecs[5] = '{16'hFFFC, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[6] = '{16'h0003, 32'h5555_5555, 4'h0, 2'b00, 32'h99A5_0001, 2'b00};

        // Outputs while reset is held.
        tick; tick;
        chk("rst_awready", 32'(awready_o), 32'd0);
        chk("rst_wready", 32'(wready_o), 32'd0);
        chk("rst_arready", 32'(arready_s), 32'd0);
        chk("rst_bvalid", 32'(bvalid_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_s), 32'd0);
        chk("rst_bresp", 32'(bresp_o), 32'd0);
        chk("rst_rresp", 32'(rresp_s), 32'd0);
        chk("rst_rdata", rdata_s, 32'd0);
        rst = 0;
        tick;
        chk("post_rst_awready", 32'(awready_o), 32'd1);
        chk("post_rst_arready", 32'(arready_s), 32'd1);

        // Same-cycle AW+W, then read back at latency 1.
        do_write(16'h0010, 32'hDEAD_BEEF, 4'hF, 3'b000, r, lat);
        chk("t1_bresp", 32'(r), 32'd0);
        chk("t1_blat", 32'(lat), 32'd1);
        do_read(16'h0010, 3'b000, d, rr, rlat);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_rresp", 32'(rr), 32'd0);
        chk("t1_rlat", 32'(rlat), 32'd0);

        // W three cycles ahead of AW, partial strobes.
        wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1;
        chk("t2_wready_idle", 32'(wready_o), 32'd1);
        tick; wvalid = 0;
        chk("t2_wready_held0", 32'(wready_o), 32'd0);
        tick;
        chk("t2_wready_held1", 32'(wready_o), 32'd0);
        tick;
        chk("t2_wready_held2", 32'(wready_o), 32'd0);
        chk("t2_bvalid_early", 32'(bvalid_o), 32'd0);
        awaddr = 16'h0010; awprot = 3'b000; awvalid = 1;
        tick; awvalid = 0;
        chk("t2_bvalid_commit", 32'(bvalid_o), 32'd0);
        tick;
        chk("t2_bvalid", 32'(bvalid_o), 32'd1);
        chk("t2_bresp", 32'(bresp_o), 32'd0);
        chk("t2_wready_free", 32'(wready_o), 32'd1);
        bready = 1; tick; bready = 0;
        chk("t2_bvalid_drop", 32'(bvalid_o), 32'd0);
        do_read(16'h0010, 3'b000, d, rr, rlat);
        chk("t2_rdata", d, 32'hDE22_BE44);

        // Vector table: write, then read back the same address.
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 3'b000, r, lat);
            chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_bresp));
            chk($sformatf("v%0d_blat", i), 32'(lat), 32'd1);
            do_read(vecs[i].addr, 3'b000, d, rr, rlat);
            chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("v%0d_rresp", i), 32'(rr), 32'(vecs[i].exp_rresp));
            chk($sformatf("v%0d_rlat", i), 32'(rlat), 32'd0);
        end

        // Latency-4 instance with a stalled R channel.
        sel4 = 1;
        tick;
        chk("t4_arready_idle", 32'(arready_s), 32'd1);
        araddr = 16'h0000; arprot = 3'b000; arvalid = 1;
        tick; arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_rvalid_wait%0d", i), 32'(rvalid_s), 32'd0);
            chk($sformatf("t4_arready_wait%0d", i), 32'(arready_s), 32'd0);
            tick;
        end
        chk("t4_rvalid", 32'(rvalid_s), 32'd1);
        chk("t4_rdata", rdata_s, 32'h99A5_0001);
        held = rdata_s;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("t4_rvalid_hold%0d", i), 32'(rvalid_s), 32'd1);
            chk($sformatf("t4_rdata_hold%0d", i), rdata_s, held);
            chk($sformatf("t4_arready_hold%0d", i), 32'(arready_s), 32'd0);
        end
        rready = 1; tick; rready = 0;
        chk("t4_rvalid_done", 32'(rvalid_s), 32'd0);
        chk("t4_arready_done", 32'(arready_s), 32'd1);
        $display("read  addr=0000 inst=4 stalled rdata=%h", held);
        sel4 = 0;

        // AR on the same edge as a commit to that word sees the old contents.
        do_write(16'h0030, 32'hAAAA_5555, 4'hF, 3'b000, r, lat);
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1;
        tick; wvalid = 0;
        awaddr = 16'h0030; awvalid = 1;
        tick; awvalid = 0;
        araddr = 16'h0030; arprot = 3'b000; arvalid = 1;
        tick; arvalid = 0;
        chk("ow_rvalid", 32'(rvalid_s), 32'd1);
        chk("ow_rdata_old", rdata_s, 32'hAAAA_5555);
        chk("ow_bvalid", 32'(bvalid_o), 32'd1);
        rready = 1; bready = 1; tick; rready = 0; bready = 0;
        do_read(16'h0030, 3'b000, d, rr, rlat);
        chk("ow_rdata_new", d, 32'h5555_AAAA);

        // Reset with a held AW and a pending read response.
        do_write(16'h0020, 32'hCAFE_F00D, 4'hF, 3'b000, r, lat);
        awaddr = 16'h0020; awvalid = 1;
        tick; awvalid = 0;
        araddr = 16'h0020; arvalid = 1;
        tick; arvalid = 0;
        chk("t5_rvalid_pending", 32'(rvalid_s), 32'd1);
        rst = 1;
        #1;
        chk("t5_rst_awready", 32'(awready_o), 32'd0);
        chk("t5_rst_rvalid", 32'(rvalid_s), 32'd0);
        tick;
        rst = 0;
        #1;
        chk("t5_awready", 32'(awready_o), 32'd1);
        chk("t5_arready", 32'(arready_s), 32'd1);
        chk("t5_rvalid", 32'(rvalid_s), 32'd0);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
        tick; wvalid = 0;
        bv = 0;
        for (int i = 0; i < 3; i++) begin bv |= bvalid_o; tick; end
        bv |= bvalid_o;
        chk("t5_no_bvalid", 32'(bv), 32'd0);
        awaddr = 16'h0024; awvalid = 1;
        tick; awvalid = 0;
        tick;
        chk("t5_bvalid_late", 32'(bvalid_o), 32'd1);
        bready = 1; tick; bready = 0;
        do_read(16'h0020, 3'b000, d, rr, rlat);
        chk("t5_rdata_prior", d, 32'hCAFE_F00D);
        do_read(16'h0024, 3'b000, d, rr, rlat);
        chk("t5_rdata_new", d, 32'h1234_5678);

        do_write(16'h07FC, 32'h0000_07FC, 4'hF, 3'b000, r, lat);
        chk("p_below_bresp", 32'(r), 32'd0);
`ifdef AXIL_RAM_PROT_EN
        do_write(16'h0800, 32'h600D_0001, 4'hF, 3'b001, r, lat);
        chk("p_priv_bresp0", 32'(r), 32'd0);
        do_write(16'h0800, 32'hBAD0_0000, 4'hF, 3'b000, r, lat);
        chk("p_unpriv_bresp", 32'(r), 32'd2);
        do_read(16'h0800, 3'b001, d, rr, rlat);
        chk("p_nowrite_rdata", d, 32'h600D_0001);
        do_read(16'h0800, 3'b000, d, rr, rlat);
        chk("p_unpriv_rresp", 32'(rr), 32'd2);
        chk("p_unpriv_rdata", d, 32'd0);
        do_write(16'h0800, 32'h600D_0002, 4'hF, 3'b001, r, lat);
        chk("p_priv_bresp1", 32'(r), 32'd0);
        do_read(16'h0800, 3'b001, d, rr, rlat);
        chk("p_priv_rdata", d, 32'h600D_0002);
`else
        do_write(16'h0800, 32'h600D_0003, 4'hF, 3'b000, r, lat);
        chk("p_open_bresp", 32'(r), 32'd0);
        do_read(16'h0800, 3'b000, d, rr, rlat);
        chk("p_open_rresp", 32'(rr), 32'd0);
        chk("p_open_rdata", d, 32'h600D_0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
